// File: rtl/alert_event_aggregator.sv
// alert_event_aggregator
//   Gathers peripheral fault events into sticky cause bits and turns them into
//   a four-phase req/ack handshake toward the alert sender. Recoverable events
//   produce one request per burst followed by a hold-off window; fatal events
//   latch until reset and keep re-issuing the request.
//
// Ports
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   event_i      per-event strobes, sampled every cycle
//   test_i       test strobe: one recoverable request, not recorded in cause
//   cause_clr_i  clear strobes for recoverable cause bits
//   alert_ack_i  acknowledge from the alert sender
//   alert_req_o  alert request
//   cause_o      sticky cause bits
//   fatal_o      fatal condition latched
//   busy_o       handshake/hold-off in progress (FSM not idle)
module alert_event_aggregator #(
  parameter int unsigned          NEvents    = 8,
  parameter logic [NEvents-1:0]   FatalMask  = '0,
  parameter int unsigned          HoldOffCyc = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NEvents-1:0] event_i,
  input  logic               test_i,
  input  logic [NEvents-1:0] cause_clr_i,
  input  logic               alert_ack_i,
  output logic               alert_req_o,
  output logic [NEvents-1:0] cause_o,
  output logic               fatal_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK_LOW = 2'd2,
    HOLDOFF = 2'd3
  } state_e;

  // Counter is loaded with HoldOffCyc-1 so that HOLDOFF lasts HoldOffCyc cycles.
  localparam logic [7:0] HoldLoad = (HoldOffCyc == 0) ? 8'd0 : 8'(HoldOffCyc - 1);

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               pending_q, pending_d;
  logic [NEvents-1:0] cause_q, cause_d;
  logic               fatal_q, fatal_d;

  logic fatal_evt;
  logic any_evt;
  logic trigger;

  assign fatal_evt = |(event_i & FatalMask);
  assign any_evt   = (|event_i) | test_i;
  assign trigger   = pending_q | any_evt;

  // Cause/fatal bookkeeping: set wins over clear; fatal bits cannot be cleared.
  always_comb begin
    cause_d = (cause_q & ~(cause_clr_i & ~FatalMask)) | event_i;
    fatal_d = fatal_q | fatal_evt;
  end

  // State register and datapath flops
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      cause_q   <= '0;
      fatal_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      cause_q   <= cause_d;
      fatal_q   <= fatal_d;
    end
  end

  // Next-state logic; pending accumulates everything seen outside IDLE and is
  // cleared (with same-cycle events consumed) whenever a new request starts.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d   = REQ;
          pending_d = 1'b0;
        end
      end
      REQ: begin
        pending_d = pending_q | any_evt;
        if (alert_ack_i) state_d = ACK_LOW;
      end
      ACK_LOW: begin
        pending_d = pending_q | any_evt;
        if (!alert_ack_i) begin
          if (fatal_q || fatal_evt) begin
            state_d   = REQ;
            pending_d = 1'b0;
          end else if (HoldOffCyc == 0) begin
            state_d = IDLE;
          end else begin
            state_d = HOLDOFF;
            cnt_d   = HoldLoad;
          end
        end
      end
      HOLDOFF: begin
        pending_d = pending_q | any_evt;
        if (fatal_evt) begin
          // A fatal event aborts the hold-off window immediately.
          state_d   = REQ;
          pending_d = 1'b0;
          cnt_d     = '0;
        end else if (cnt_q == '0) begin
          if (fatal_q || trigger) begin
            state_d   = REQ;
            pending_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from flops only
  always_comb begin
    alert_req_o = (state_q == REQ);
    busy_o      = (state_q != IDLE);
    cause_o     = cause_q;
    fatal_o     = fatal_q;
  end

endmodule

// File: tb/tb_alert_event_aggregator.sv
module tb_alert_event_aggregator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: recoverable only, hold-off 16
  logic [7:0] ev_a = '0, clr_a = '0, cause_a;
  logic test_a = 1'b0, ack_a = 1'b0, req_a, fatal_a, busy_a;
  // DUT B: event 7 fatal, hold-off 16
  logic [7:0] ev_b = '0, clr_b = '0, cause_b;
  logic test_b = 1'b0, ack_b = 1'b0, req_b, fatal_b, busy_b;
  // DUT C: no hold-off
  logic [7:0] ev_c = '0, clr_c = '0, cause_c;
  logic test_c = 1'b0, ack_c = 1'b0, req_c, fatal_c, busy_c;

  alert_event_aggregator #(.NEvents(8), .FatalMask(8'h00), .HoldOffCyc(16)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .event_i(ev_a), .test_i(test_a), .cause_clr_i(clr_a),
    .alert_ack_i(ack_a), .alert_req_o(req_a), .cause_o(cause_a), .fatal_o(fatal_a),
    .busy_o(busy_a));

  alert_event_aggregator #(.NEvents(8), .FatalMask(8'h80), .HoldOffCyc(16)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .event_i(ev_b), .test_i(test_b), .cause_clr_i(clr_b),
    .alert_ack_i(ack_b), .alert_req_o(req_b), .cause_o(cause_b), .fatal_o(fatal_b),
    .busy_o(busy_b));

  alert_event_aggregator #(.NEvents(8), .FatalMask(8'h00), .HoldOffCyc(0)) u_dut_c (
    .clk_i(clk), .rst_i(rst), .event_i(ev_c), .test_i(test_c), .cause_clr_i(clr_c),
    .alert_ack_i(ack_c), .alert_req_o(req_c), .cause_o(cause_c), .fatal_o(fatal_c),
    .busy_o(busy_c));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the edge (sample/drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  int hi, reqs;

  initial begin
    do_reset();

    // Reset state
    check("rst_req",   req_a,   0);
    check("rst_cause", cause_a, 0);
    check("rst_fatal", fatal_a, 0);
    check("rst_busy",  busy_a,  0);

    // ---- Recoverable single event ----
    ev_a = 8'h04; tick(); ev_a = '0;
    check("rec_req",   req_a,   1);
    check("rec_cause", cause_a, 8'h04);
    check("rec_busy",  busy_a,  1);
    check("rec_fatal", fatal_a, 0);
    tick(); tick();
    check("rec_req_hold", req_a, 1);
    ack_a = 1'b1; tick();
    check("rec_req_low", req_a, 0);
    tick(); ack_a = 1'b0; tick();   // ack low sampled in P; now at P+1
    hi = 0; reqs = 0;
    for (int i = 0; i < 16; i++) begin
      if (busy_a) hi++;
      if (req_a) reqs++;
      tick();
    end
    check("rec_holdoff_len", hi, 16);
    check("rec_busy_end", busy_a, 0);
    check("rec_no_req_hold", reqs, 0);
    for (int i = 0; i < 5; i++) begin
      if (req_a) reqs++;
      tick();
    end
    check("rec_no_second_req", reqs, 0);

    // ---- Accumulation during REQ ----
    do_reset();
    ev_a = 8'h01; tick(); ev_a = '0;
    check("acc_req", req_a, 1);
    ev_a = 8'h02; tick(); ev_a = '0;
    tick();
    ev_a = 8'h20; tick(); ev_a = '0;
    check("acc_cause", cause_a, 8'h23);
    ack_a = 1'b1; tick();
    ack_a = 1'b0; tick();           // now at P+1
    reqs = 0;
    for (int i = 0; i < 16; i++) begin
      if (req_a) reqs++;
      tick();
    end
    check("acc_quiet_holdoff", reqs, 0);
    check("acc_second_req", req_a, 1);
    ack_a = 1'b1; tick();
    ack_a = 1'b0; tick();
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_a) reqs++;
      tick();
    end
    check("acc_no_third_req", reqs, 0);
    check("acc_idle", busy_a, 0);

    // ---- Clear/set collision ----
    clr_a = 8'hFF; tick(); clr_a = '0;
    check("clr_all", cause_a, 8'h00);
    ev_a = 8'h01; tick(); ev_a = '0;
    check("col_set", cause_a, 8'h01);
    clr_a = 8'h01; ev_a = 8'h01; tick(); ev_a = '0;
    check("col_set_wins", cause_a, 8'h01);
    tick(); clr_a = '0;
    check("col_clear", cause_a, 8'h00);

    // ---- Fatal ----
    do_reset();
    ev_b = 8'h80; tick(); ev_b = '0;
    check("fat_fatal", fatal_b, 1);
    check("fat_req",   req_b,   1);
    check("fat_cause", cause_b, 8'h80);
    for (int i = 0; i < 4; i++) begin
      ack_b = 1'b1; tick();
      check("fat_req_low", req_b, 0);
      ack_b = 1'b0; tick();
      check("fat_req_reissue", req_b, 1);
    end
    clr_b = 8'hFF; tick(); clr_b = '0;
    check("fat_clr_cause", cause_b, 8'h80);
    check("fat_still", fatal_b, 1);

    // ---- Async reset mid-handshake ----
    ack_b = 1'b1;
    rst = 1'b1; #1;
    check("arst_req",   req_b,   0);
    check("arst_fatal", fatal_b, 0);
    check("arst_cause", cause_b, 0);
    check("arst_busy",  busy_b,  0);
    tick(); rst = 1'b0;
    tick(); tick(); tick();
    check("arst_ack_ignored_busy", busy_b, 0);
    check("arst_ack_ignored_req",  req_b,  0);
    ack_b = 1'b0;

    // ---- test_i with no hold-off ----
    do_reset();
    test_c = 1'b1; tick(); test_c = 1'b0;
    check("tst_req",   req_c,   1);
    check("tst_cause", cause_c, 0);
    ack_c = 1'b1; tick();
    check("tst_req_low", req_c, 0);
    ack_c = 1'b0; tick();
    check("tst_idle", busy_c, 0);
    check("tst_single_req", req_c, 0);
    test_c = 1'b1; tick(); test_c = 1'b0;
    check("tst_b2b_req", req_c, 1);
    check("tst_b2b_cause", cause_c, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
